// File: rtl/store_pkg.sv
// Shared types and constants for the store-side buffer controller.
package store_pkg;

  localparam logic [6:0] STORE_OP = 7'b0100011;

  localparam logic [3:0] WE_B = 4'b0001;
  localparam logic [3:0] WE_H = 4'b0011;
  localparam logic [3:0] WE_W = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } store_state_e;

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO of store entries; head reads zero while empty.
module store_fifo
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  store_entry_t                 din,
  output store_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  store_entry_t mem_q [DEPTH];
  store_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer: alignment check and lane shift, FIFO queueing, and a
// req/ack drain FSM with timeout detection and fence support.
module store_buffer_ctrl
  import store_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_wr_en,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        fence_req,
  output logic        fence_done,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  store_state_e  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          misalign_q, misalign_d;

  store_entry_t  new_entry, head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          transfer, legal, push, pop, flush;

  assign st_ready     = !full && !fence_req && (state_q != ERR);
  assign transfer     = st_valid && st_ready;
  assign mem_req      = (state_q == ISSUE);
  assign timeout_err  = (state_q == ERR);
  assign misalign_err = misalign_q;
  assign fence_done   = empty && (state_q == IDLE);
  assign mem_addr     = head.addr;
  assign mem_wdata    = head.wdata;
  assign mem_be       = head.be;

  // Legality check and lane placement of an incoming store.
  always_comb begin
    legal           = 1'b0;
    new_entry.addr  = {st_addr[31:2], 2'b00};
    new_entry.be    = 4'(st_wr_en << st_addr[1:0]);
    new_entry.wdata = 32'(st_data << {st_addr[1:0], 3'b000});
    if (st_wr_en == WE_B) begin
      legal = 1'b1;
    end else if (st_wr_en == WE_H) begin
      legal = !st_addr[0];
    end else if (st_wr_en == WE_W) begin
      legal = (st_addr[1:0] == 2'b00);
    end
    push       = transfer && legal;
    misalign_d = transfer && (st_wr_en != 4'b0000) && !legal;
  end

  // Drain FSM and timeout counter.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = ISSUE;
          tmo_d   = '0;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          pop   = 1'b1;
          tmo_d = '0;
          if ((count > CW'(1)) || push) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ERR: begin
        flush = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      misalign_q <= misalign_d;
    end
  end

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (new_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: single-store vector table plus
// hand-written sequences for fill, timeout, fence and reset corners.
module tb_store_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_wr_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        fence_req;
  logic        fence_done;
  logic        misalign_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer_ctrl #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_wr_en     (st_wr_en),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .fence_req    (fence_req),
    .fence_done   (fence_done),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
    logic        enq;
    logic        mis;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one store for a single cycle; returns just after the following negedge.
  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_wr_en = w;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int high;
    int acks;
    int done_i;
    logic any_req;
    logic [31:0] seen [4];

    vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 4'b0001, 1'b1, 1'b0, 32'h0000_1000, 32'hAB00_0000, 4'b1000};
    vecs[1] = '{32'h0000_2002, 32'h0000_1234, 4'b0011, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_0000, 4'b1100};
    vecs[2] = '{32'h0000_2001, 32'h0000_1234, 4'b0011, 1'b0, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[3] = '{32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111};
    vecs[4] = '{32'h0000_3002, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[5] = '{32'h0000_4001, 32'h0000_0055, 4'b0001, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_5500, 4'b0010};
    vecs[6] = '{32'h0000_4000, 32'h1111_1111, 4'b0000, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[7] = '{32'h0000_4000, 32'h1111_1111, 4'b0101, 1'b0, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[8] = '{32'h0000_5000, 32'hFFFF_BEEF, 4'b0011, 1'b1, 1'b0, 32'h0000_5000, 32'hFFFF_BEEF, 4'b0011};
    vecs[9] = '{32'h8000_0007, 32'h0000_00C3, 4'b0001, 1'b1, 1'b0, 32'h8000_0004, 32'hC300_0000, 4'b1000};

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_wr_en = '0;
    mem_ack = 1'b0; fence_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset misalign_err", 32'(misalign_err), 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    check("reset fence_done", 32'(fence_done), 32'd1);
    check("reset st_ready", 32'(st_ready), 32'd1);
    check("reset mem_addr", mem_addr, 32'd0);

    // Table: single stores against an always-ack memory
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(vecs[i].addr, vecs[i].data, vecs[i].we);
      check($sformatf("v%0d misalign", i), 32'(misalign_err), 32'(vecs[i].mis));
      check($sformatf("v%0d req idle", i), 32'(mem_req), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d req", i), 32'(mem_req), 32'(vecs[i].enq));
      check($sformatf("v%0d misalign clr", i), 32'(misalign_err), 32'd0);
      if (vecs[i].enq) begin
        check($sformatf("v%0d addr", i), mem_addr, vecs[i].eaddr);
        check($sformatf("v%0d wdata", i), mem_wdata, vecs[i].ewdata);
        check($sformatf("v%0d be", i), 32'(mem_be), 32'(vecs[i].ebe));
        @(negedge clk);
        check($sformatf("v%0d req done", i), 32'(mem_req), 32'd0);
      end
      check($sformatf("v%0d fence_done", i), 32'(fence_done), 32'd1);
    end

    // sb acked on the second request cycle
    mem_ack = 1'b0;
    push_one(32'h0000_1003, 32'h0000_00AB, 4'b0001);
    @(negedge clk);
    check("p1 req c1", 32'(mem_req), 32'd1);
    check("p1 addr", mem_addr, 32'h0000_1000);
    check("p1 be", 32'(mem_be), 32'h8);
    check("p1 wdata", mem_wdata, 32'hAB00_0000);
    @(negedge clk);
    check("p1 req c2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("p1 req end", 32'(mem_req), 32'd0);
    check("p1 fence_done", 32'(fence_done), 32'd1);

    // Fill the FIFO with acks withheld, then drain in order
    for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'h100 + 32'(i), 4'b1111);
    check("fill st_ready", 32'(st_ready), 32'd0);
    check("fill head", mem_addr, 32'h0);
    check("fill req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    check("fill st_ready after ack", 32'(st_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("drain req %0d", i), 32'(mem_req), 32'd1);
      check($sformatf("drain addr %0d", i), mem_addr, 32'(4 * i));
      check($sformatf("drain data %0d", i), mem_wdata, 32'h100 + 32'(i));
      @(negedge clk);
    end
    check("drain idle", 32'(mem_req), 32'd0);
    check("drain fence_done", 32'(fence_done), 32'd1);

    // Timeout with a never-acking memory
    mem_ack = 1'b0;
    high = 0;
    push_one(32'h0000_0100, 32'h5A5A_5A5A, 4'b1111);
    for (int i = 0; i < 40; i++) begin
      if (mem_req) high++;
      else if (high > 0) break;
      @(negedge clk);
    end
    check("tmo req cycles", 32'(high), 32'd15);
    check("tmo err", 32'(timeout_err), 32'd1);
    check("tmo req low", 32'(mem_req), 32'd0);
    repeat (3) @(negedge clk);
    check("tmo err sticky", 32'(timeout_err), 32'd1);
    check("tmo st_ready", 32'(st_ready), 32'd0);
    check("tmo fence_done", 32'(fence_done), 32'd0);
    check("tmo flushed head", mem_addr, 32'd0);
    do_reset();
    check("tmo rst err", 32'(timeout_err), 32'd0);
    check("tmo rst st_ready", 32'(st_ready), 32'd1);

    // Fence with three queued stores and a held store request
    push_one(32'h0000_0010, 32'h1, 4'b0001);
    push_one(32'h0000_0020, 32'h2, 4'b0001);
    push_one(32'h0000_0030, 32'h3, 4'b0001);
    fence_req = 1'b1;
    st_valid = 1'b1; st_addr = 32'h0000_0040; st_data = 32'h4; st_wr_en = 4'b0001;
    #1;
    check("fence st_ready", 32'(st_ready), 32'd0);
    check("fence done early", 32'(fence_done), 32'd0);
    mem_ack = 1'b1;
    acks = 0;
    done_i = -1;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        if (acks < 4) seen[acks] = mem_addr;
        acks++;
      end else if (fence_done) begin
        done_i = i;
        break;
      end
      @(negedge clk);
    end
    check("fence acks", 32'(acks), 32'd3);
    check("fence done cycle", 32'(done_i), 32'd3);
    check("fence order 0", seen[0], 32'h10);
    check("fence order 1", seen[1], 32'h20);
    check("fence order 2", seen[2], 32'h30);
    repeat (3) @(negedge clk);
    check("fence blocked store", 32'(mem_req), 32'd0);
    st_valid = 1'b0;
    fence_req = 1'b0;
    @(negedge clk);

    // Reset during ISSUE drops queued entries
    mem_ack = 1'b0;
    push_one(32'h0000_0200, 32'h7, 4'b1111);
    push_one(32'h0000_0204, 32'h8, 4'b1111);
    check("rst pre req", 32'(mem_req), 32'd1);
    do_reset();
    check("rst req", 32'(mem_req), 32'd0);
    check("rst fence_done", 32'(fence_done), 32'd1);
    any_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) any_req = 1'b1;
    end
    check("rst no req", 32'(any_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
Store-side controller sitting between the S-type store decoder (`s_type`) and data memory.
- Accepts decoded stores (`d_addr`, `d_data`, `wr_en`) over a valid/ready handshake.
- Checks alignment, lane-shifts data and byte enables, and queues entries in a small FIFO.
- Drains entries to memory one at a time over a req/ack handshake, with timeout detection and a fence/drain interface for the pipeline.

Parameters:
- DEPTH, 4: store FIFO entries (power of two, ≥2).
- TIMEOUT, 15: max cycles `mem_req` may stay high on one entry without `mem_ack` (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_valid  in  1  store request valid
- st_ready  out  1  controller can accept a store
- st_addr  in  32  byte address (`d_addr`)
- st_data  in  32  store data, unshifted (`d_data`)
- st_wr_en  in  4  size mask from decoder: 0001=sb, 0011=sh, 1111=sw
- mem_req  out  1  memory write request
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-shifted write data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory accepted head write (sampled only while mem_req=1)
- fence_req  in  1  level: drain buffer, block new stores
- fence_done  out  1  buffer empty and idle
- misalign_err  out  1  one-cycle pulse for a rejected store
- timeout_err  out  1  sticky memory-timeout error

Behaviour:
- Reset values:
  - mem_req=0, misalign_err=0, timeout_err=0.
  - FIFO pointers and count = 0; state = IDLE; timeout counter = 0.
  - Consequently fence_done=1 and st_ready=1 in the first cycle after rst deasserts.
  - Reset mid-ISSUE drops all entries; mem_req is 0 the cycle after rst is sampled.
- st_ready = !full && !fence_req && state!=ERR. It is computed from the registered count, so a same-cycle dequeue does not free a slot until the next cycle.
- Handshake: a transfer occurs when st_valid && st_ready.
- Legality check at transfer:
  - st_wr_en=0000: accepted and silently dropped.
  - sh with addr[0]=1, sw with addr[1:0]≠0, or any other mask: accepted, not enqueued; misalign_err=1 for exactly the next cycle.
  - Legal stores are enqueued as:
    - addr = {st_addr[31:2], 2'b00}
    - be = st_wr_en << st_addr[1:0]
    - wdata = st_data << (8*st_addr[1:0])
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH+1) bits.
  - Simultaneous push and pop leaves count unchanged.
- mem_addr, mem_wdata and mem_be are driven from the FIFO head and are stable while mem_req=1. They read 0 when the FIFO is empty.
- FSM:
  - IDLE (mem_req=0): goes to ISSUE when count>0.
  - ISSUE (mem_req=1):
    - On mem_ack, pop the head.
    - Stay in ISSUE if entries remain after the pop (a same-cycle push counts); otherwise go to IDLE.
    - Back-to-back stores therefore proceed at one per cycle with an always-ack memory.
  - ERR (mem_req=0): entered on timeout. timeout_err=1 and the FIFO is flushed. Exit only via rst.
- Timeout counter:
  - Cleared on entry to ISSUE and on every ack.
  - Increments each ISSUE cycle without ack.
  - If counter==TIMEOUT-1 and there is no ack, go to ERR next cycle; mem_req is therefore high for exactly TIMEOUT cycles.
  - An ack on the TIMEOUT-th cycle succeeds.
- fence_done = (count==0) && state==IDLE, combinational. It is 0 in ERR.
- The pipeline stalls on !st_ready. fence_req held with an empty buffer gives fence_done=1 immediately.

Decomposition:
- Package `store_pkg`:
  - STORE_OP=7'b0100011.
  - Mask constants WE_B=4'b0001, WE_H=4'b0011, WE_W=4'b1111.
  - `store_entry_t` struct {addr[31:0], wdata[31:0], be[3:0]}.
  - `store_state_e` enum {IDLE, ISSUE, ERR}.
- Sub-module `store_fifo`: parameterised synchronous FIFO of `store_entry_t` with push, pop, full, empty and count; it resets on rst. The controller holds the alignment logic, FSM and timeout counter.

Test Plan:
1. sb, st_addr=0x0000_1003, st_data=0xAB, memory acks on the 2nd req cycle → mem_addr=0x1000, mem_be=1000, mem_wdata=0xAB00_0000; mem_req high exactly 2 cycles, then fence_done=1.
2. sh at 0x2002, data 0x1234 → be=1100, wdata=0x1234_0000. Then sh at 0x2001 → misalign_err pulses one cycle, no mem_req, count stays 0.
3. mem_ack held 0, push 4 sw (0x0, 0x4, 0x8, 0xC) → st_ready=0 after the 4th. Ack once → st_ready=1 the cycle after. Always-ack thereafter → remaining stores drained in consecutive cycles, in order.
4. TIMEOUT=15, one sw, never ack → mem_req high exactly 15 cycles, then timeout_err=1, mem_req=0, st_ready=0 until rst. After rst: timeout_err=0, st_ready=1.
5. 3 stores queued, fence_req=1 → st_ready=0 immediately; fence_done rises the cycle after the 3rd ack; st_valid held during the fence is not accepted.
6. rst asserted while in ISSUE with 2 entries → next cycle mem_req=0, fence_done=1, and no further mem_req without new stores.
